switch_rr_arb: RTL and testbench

SWITCH_RR_ARB -- requirements
Module: switch_rr_arb

---
 rtl/switch_rr_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 32 +++
 rtl/switch_rr_arb.sv | 79 +++++++
 tb/tb_switch_rr_arb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/switch_rr_arb_pkg.sv
// switch_rr_arb_pkg: shared state type and default constants.
// Used by switch_rr_arb and rr_pick.
package switch_rr_arb_pkg;

  localparam int WIDTH_D    = 64;
  localparam int CHANNELS_D = 4;
  localparam int CNT_W      = 32;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner search starting after last.
// Ports: req, last in; gnt (one-hot), idx, any out.
module rr_pick import switch_rr_arb_pkg::*; #(
  parameter int N  = CHANNELS_D,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int c;

  // Walk last+1 .. last+N modulo N; first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last) + k) % N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/switch_rr_arb.sv
// switch_rr_arb: round-robin N:1 switch into a one-entry output register.
// Ports: clk, rst (async low), in_data/in_en/in_grant, out_data/out_valid/out_ready; xfer_count with SWITCH_RR_ARB_STATS_EN.
module switch_rr_arb import switch_rr_arb_pkg::*; #(
  parameter int WIDTH    = WIDTH_D,
  parameter int CHANNELS = CHANNELS_D
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_en,
  output logic [CHANNELS-1:0]       in_grant,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef SWITCH_RR_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]          xfer_count
`endif
);

  localparam int IW = $clog2(CHANNELS);

  state_t              state;
  logic [IW-1:0]       last;
  logic [CHANNELS-1:0] gnt;
  logic [IW-1:0]       idx;
  logic                any;
  logic                cap;
  logic [WIDTH-1:0]    sel;

  rr_pick #(
    .N  (CHANNELS),
    .IW (IW)
  ) u_pick (
    .req  (in_en),
    .last (last),
    .gnt  (gnt),
    .idx  (idx),
    .any  (any)
  );

  // Capture whenever the slot is free or drains this cycle.
  assign cap = any && ((state == EMPTY) || out_ready);
  assign sel = in_data[idx*WIDTH +: WIDTH];

  // rst gates the grant so it is quiet during reset.
  assign in_grant  = (rst && cap) ? gnt : '0;
  assign out_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      out_data <= '0;
      last     <= IW'(CHANNELS - 1);
    end else if (cap) begin
      state    <= FULL;
      out_data <= sel;
      last     <= idx;
    end else if (out_ready) begin
      state    <= EMPTY;
      out_data <= '0;
    end
  end

`ifdef SWITCH_RR_ARB_STATS_EN
  logic [CNT_W-1:0] xfer_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  assign xfer_count = xfer_cnt;
`endif

endmodule

// File: tb/tb_switch_rr_arb.sv
// tb_switch_rr_arb: directed table plus randomized model check.
// Exercises switch_rr_arb with CHANNELS=4, WIDTH=64.
module tb_switch_rr_arb;

  logic          clk = 1'b0;
  logic          rst;
  logic [255:0]  in_data;
  logic [3:0]    in_en;
  logic [3:0]    in_grant;
  logic [63:0]   out_data;
  logic          out_valid;
  logic          out_ready;
`ifdef SWITCH_RR_ARB_STATS_EN
  logic [31:0]   xfer_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_rr_arb #(
    .WIDTH    (64),
    .CHANNELS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_en     (in_en),
    .in_grant  (in_grant),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SWITCH_RR_ARB_STATS_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  typedef struct {
    logic [3:0]  en;
    logic        rdy;
    logic [3:0]  g;
    logic        v;
    logic [63:0] d;
  } vec_t;

  vec_t tbl[$];

  bit          m_valid;
  logic [63:0] m_data;
  int          m_last;
  int unsigned m_xfer;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string nm);
    @(negedge clk);
    in_en     = t.en;
    out_ready = t.rdy;
    #1;
    chk({nm, " grant"}, 64'(in_grant), 64'(t.g));
    chk({nm, " valid"}, 64'(out_valid), 64'(t.v));
    chk({nm, " data"}, out_data, t.d);
  endtask

  task automatic run_tbl(input string nm);
    foreach (tbl[i])
      apply(tbl[i], $sformatf("%s[%0d]", nm, i));
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    in_en     = 4'hf;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst grant", 64'(in_grant), 64'h0);
      chk("rst valid", 64'(out_valid), 64'h0);
      chk("rst data", out_data, 64'h0);
      @(negedge clk);
    end
    rst     = 1'b1;
    in_en   = 4'h0;
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 3;
    m_xfer  = 0;
  endtask

  function automatic int winner(input logic [3:0] en, input int last);
    for (int k = 1; k <= 4; k++)
      if (en[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic rand_cycle();
    int          w;
    bit          capt;
    logic [3:0]  eg;
    @(negedge clk);
    for (int i = 0; i < 8; i++)
      in_data[i*32 +: 32] = $urandom;
    in_en     = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) in_en = 4'h0;
    out_ready = ($urandom_range(0, 2) != 0);
    #1;
    w    = winner(in_en, m_last);
    capt = (w >= 0) && (!m_valid || out_ready);
    eg   = capt ? 4'(1 << w) : 4'h0;
    chk("rnd grant", 64'(in_grant), 64'(eg));
    chk("rnd valid", 64'(out_valid), 64'(m_valid));
    chk("rnd data", out_data, m_data);
    if (m_valid && out_ready) m_xfer++;
    if (capt) begin
      m_valid = 1'b1;
      m_data  = in_data[w*64 +: 64];
      m_last  = w;
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_data  = '0;
    end
  endtask

  initial begin
    rst       = 1'b0;
    in_en     = 4'h0;
    out_ready = 1'b0;
    in_data   = {64'h44, 64'hC8E, 64'h22, 64'h11};

    do_reset();

    tbl.push_back('{4'b0100, 1'b1, 4'b0100, 1'b0, 64'h0});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, 64'hC8E});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 64'h0});
    tbl.push_back('{4'b0001, 1'b0, 4'b0001, 1'b0, 64'h0});
    run_tbl("single");

    #3;
    rst = 1'b0;
    #1;
    chk("midrst valid", 64'(out_valid), 64'h0);
    chk("midrst data", out_data, 64'h0);
    chk("midrst grant", 64'(in_grant), 64'h0);
    do_reset();

    tbl.push_back('{4'b1111, 1'b1, 4'b0001, 1'b0, 64'h0});
    tbl.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 64'h11});
    tbl.push_back('{4'b1111, 1'b1, 4'b0100, 1'b1, 64'h22});
    tbl.push_back('{4'b1111, 1'b1, 4'b1000, 1'b1, 64'hC8E});
    tbl.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 64'h44});
    tbl.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 64'h11});
    tbl.push_back('{4'b1111, 1'b1, 4'b0100, 1'b1, 64'h22});
    tbl.push_back('{4'b1111, 1'b1, 4'b1000, 1'b1, 64'hC8E});
    run_tbl("rot");

    tbl.push_back('{4'b1111, 1'b0, 4'b0000, 1'b1, 64'h44});
    tbl.push_back('{4'b0101, 1'b0, 4'b0000, 1'b1, 64'h44});
    tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b1, 64'h44});
    tbl.push_back('{4'b0010, 1'b0, 4'b0000, 1'b1, 64'h44});
    tbl.push_back('{4'b1111, 1'b0, 4'b0000, 1'b1, 64'h44});
    tbl.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 64'h44});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, 64'h11});
    run_tbl("bp");

    tbl.push_back('{4'b1000, 1'b1, 4'b1000, 1'b0, 64'h0});
    tbl.push_back('{4'b0110, 1'b1, 4'b0010, 1'b1, 64'h44});
    tbl.push_back('{4'b0110, 1'b1, 4'b0100, 1'b1, 64'h22});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, 64'hC8E});
    tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 64'h0});
    run_tbl("wrap");

    do_reset();
    for (int n = 0; n < 2000; n++)
      rand_cycle();

`ifdef SWITCH_RR_ARB_STATS_EN
    #1;
    chk("rnd xfer_count", 64'(xfer_count), 64'(m_xfer));
    in_data = {64'h44, 64'hC8E, 64'h22, 64'h11};
    do_reset();
    #1;
    chk("xfer reset", 64'(xfer_count), 64'h0);
    force dut.xfer_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.xfer_cnt;
    tbl.push_back('{4'b0001, 1'b1, 4'b0001, 1'b0, 64'h0});
    tbl.push_back('{4'b0001, 1'b1, 4'b0001, 1'b1, 64'h11});
    tbl.push_back('{4'b0001, 1'b1, 4'b0001, 1'b1, 64'h11});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, 64'h11});
    tbl.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 64'h0});
    run_tbl("stats");
    chk("xfer wrap", 64'(xfer_count), 64'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
